// File: rtl/router_nch_if.sv
`default_nettype none
// ============================================================================
//  Module   : router_nch_if
//  Purpose  : Packet-side and channel-side signal bundle for router_nch.
//             The master modport belongs to the packet sender / channel
//             reader; the slave modport belongs to the router itself.
//  Signals  : packet_valid, datain         sender -> router, packet bytes
//             read_enb[NUM_CH]             reader -> router, per-channel pop
//             busy                         router -> sender, hold request
//             err, drop                    router status
//             vld_out, data_out            per-channel FIFO outputs
//             pkt_cnt, err_cnt             statistics (0 unless enabled)
//  Revision : 1.0  initial release
// ============================================================================
interface router_nch_if #(
  parameter int DW     = 8,
  parameter int NUM_CH = 3
);
  logic                   packet_valid;
  logic [DW-1:0]          datain;
  logic [NUM_CH-1:0]      read_enb;
  logic                   busy;
  logic                   err;
  logic                   drop;
  logic [NUM_CH-1:0]      vld_out;
  logic [NUM_CH*DW-1:0]   data_out;
  logic [15:0]            pkt_cnt;
  logic [15:0]            err_cnt;

  modport master (
    output packet_valid, datain, read_enb,
    input  busy, err, drop, vld_out, data_out, pkt_cnt, err_cnt
  );

  modport slave (
    input  packet_valid, datain, read_enb,
    output busy, err, drop, vld_out, data_out, pkt_cnt, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/router_nch.sv
`default_nettype none
// ============================================================================
//  Module   : router_nch
//  Purpose  : Byte-serial packet router. Each packet (header, payload,
//             XOR parity byte) is steered into one of NUM_CH FIFOs by the
//             low AW bits of its header. Invalid addresses are discarded,
//             back-pressure is a combinational busy, and a channel left
//             unread for TIMEOUT cycles is flushed.
//  Ports    : clk     clock, rising edge
//             resetn  synchronous active-low reset
//             bus     router_nch_if.slave (packet input, busy/err/drop,
//                     per-channel vld_out/data_out, optional statistics)
//  Options  : ROUTER_STATS_EN  builds saturating pkt_cnt / err_cnt counters;
//             when undefined both outputs are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module router_nch #(
  parameter int DW      = 8,
  parameter int NUM_CH  = 3,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       resetn,
  router_nch_if.slave bus
);

  localparam int            AW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [AW:0]   NCH     = (AW + 1)'(NUM_CH);
  localparam logic [7:0]    TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_DECODE, S_WAIT, S_LOAD, S_DROP} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     hdr_q, hdr_d;
  logic [DW-1:0]     par_q, par_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;

  logic              wr_en;
  logic [AW-1:0]     wr_ch;
  logic [DW-1:0]     wr_data;
  logic              busy;
  logic              par_done;
  logic [AW-1:0]     din_addr;

  logic [NUM_CH-1:0] full, empty, to_fire;

  assign din_addr = bus.datain[AW-1:0];

  // --------------------------------------------------------------------------
  // Packet FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_DECODE;
      addr_q  <= '0;
      hdr_q   <= '0;
      par_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hdr_q   <= hdr_d;
      par_q   <= par_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    hdr_d    = hdr_q;
    par_d    = par_q;
    err_d    = err_q;
    drop_d   = 1'b0;
    wr_en    = 1'b0;
    wr_ch    = addr_q;
    wr_data  = bus.datain;
    busy     = 1'b0;
    par_done = 1'b0;
    case (state_q)
      S_DECODE: begin
        if (bus.packet_valid) begin
          addr_d = din_addr;
          hdr_d  = bus.datain;
          wr_ch  = din_addr;
          if ({1'b0, din_addr} >= NCH) begin
            state_d = S_DROP;
          end else if (empty[din_addr]) begin
            wr_en   = 1'b1;
            par_d   = bus.datain;
            state_d = S_LOAD;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        // A non-empty target can time out while we wait for it to drain.
        if (to_fire[addr_q]) begin
          state_d = S_DROP;
        end else if (empty[addr_q]) begin
          wr_en   = 1'b1;
          wr_data = hdr_q;
          par_d   = hdr_q;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy = full[addr_q];
        if (to_fire[addr_q]) begin
          // The flush wins; the byte on the bus is consumed only when the
          // FIFO had room. A parity byte consumed here ends the packet.
          if (!full[addr_q] && !bus.packet_valid) begin
            drop_d  = 1'b1;
            state_d = S_DECODE;
          end else begin
            state_d = S_DROP;
          end
        end else if (!full[addr_q]) begin
          wr_en = 1'b1;
          if (bus.packet_valid) begin
            par_d = par_q ^ bus.datain;
          end else begin
            err_d    = (par_q != bus.datain);
            par_done = 1'b1;
            state_d  = S_DECODE;
          end
        end
      end
      S_DROP: begin
        if (!bus.packet_valid) begin
          drop_d  = 1'b1;
          state_d = S_DECODE;
        end
      end
      default: state_d = S_DECODE;
    endcase
  end

  assign bus.busy = busy;
  assign bus.err  = err_q;
  assign bus.drop = drop_q;

  // --------------------------------------------------------------------------
  // Per-channel FIFO, read register and timeout counter
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] dout_q;
    logic [7:0]    to_q;
    logic          we, re;

    assign we = wr_en && (wr_ch == AW'(c)) && !full[c];
    assign re = bus.read_enb[c] && !empty[c];

    assign full[c]    = (cnt_q == CW'(DEPTH));
    assign empty[c]   = (cnt_q == '0);
    // Fires on the edge where the idle counter would reach TIMEOUT.
    assign to_fire[c] = !empty[c] && !bus.read_enb[c] && (to_q == TO_LAST);

    always_ff @(posedge clk) begin
      if (we) begin
        mem[wp_q] <= wr_data;
      end
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        wp_q   <= '0;
        rp_q   <= '0;
        cnt_q  <= '0;
        dout_q <= '0;
        to_q   <= '0;
      end else if (to_fire[c]) begin
        wp_q   <= '0;
        rp_q   <= '0;
        cnt_q  <= '0;
        dout_q <= '0;
        to_q   <= '0;
      end else begin
        if (we) begin
          wp_q <= wp_q + 1'b1;
        end
        if (re) begin
          rp_q   <= rp_q + 1'b1;
          dout_q <= mem[rp_q];
        end
        cnt_q <= cnt_q + CW'(we) - CW'(re);
        to_q  <= (!empty[c] && !bus.read_enb[c]) ? to_q + 8'd1 : 8'd0;
      end
    end

    assign bus.vld_out[c]            = !empty[c];
    assign bus.data_out[c*DW +: DW] = dout_q;
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef ROUTER_STATS_EN
  logic [15:0] pkt_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (par_done) begin
      if (pkt_cnt_q != 16'hFFFF) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
      if (err_d && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign bus.pkt_cnt = pkt_cnt_q;
  assign bus.err_cnt = err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = par_done;
  assign bus.pkt_cnt  = 16'h0000;
  assign bus.err_cnt  = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/router_nch.md
Name: router_nch

Overview:
- Parametrised successor of the 3-port packet router.
- Accepts byte-serial packets framed by packet_valid: header, payload, then XOR parity byte.
- Steers each packet into one of NUM_CH output FIFOs by the header address field.
- Adds configurable width, depth, channel count and timeout; invalid-address drop; clean back-pressure via a combinational busy; per-channel timeout flush.

Parameters:
- DW, 8, data/byte width in bits (>=4).
- NUM_CH, 3, number of output channels (2..8).
- DEPTH, 16, entries per channel FIFO (power of 2, >=4).
- TIMEOUT, 30, consecutive unread-valid cycles before a channel soft-resets (1..255).
- Localparam AW = clog2(NUM_CH): header address field width.

Ports:
- clk  in  1  clock; single clock domain, all logic on its rising edge
- resetn  in  1  synchronous active-low reset
- packet_valid  in  1  high during header and payload bytes; low on the parity byte
- datain  in  DW  packet byte
- read_enb  in  NUM_CH  per-channel read request
- busy  out  1  sender must hold datain/packet_valid while high
- err  out  1  parity result of last completed packet (1 = mismatch)
- drop  out  1  one-cycle pulse when an invalid-address packet finishes discard
- vld_out  out  NUM_CH  channel FIFO non-empty
- data_out  out  NUM_CH*DW  channel c at bits [c*DW +: DW], registered read data
- pkt_cnt  out  16  completed packets (optional feature)
- err_cnt  out  16  parity-error packets (optional feature)

Behaviour:
- Reset (resetn=0 at clk edge):
  - FSM to DECODE; all FIFOs empty; pointers/counts 0.
  - data_out, err, drop, parity accumulator, timeout counters = 0.
  - busy=0; vld_out=0.
- Header format: datain[AW-1:0] = destination; upper bits are forwarded unchanged. Header is stored in the FIFO like any other byte.
- DECODE: on packet_valid=1, latch addr and header.
  - addr >= NUM_CH -> DROP.
  - FIFO[addr] empty -> write header this cycle, parity = header, go LOAD.
  - Otherwise -> WAIT.
- WAIT: busy=1. When FIFO[addr] is empty, write the held header, parity = header, go LOAD.
- LOAD:
  - busy = full[addr].
  - When not full and packet_valid=1: write datain, parity ^= datain.
  - When not full and packet_valid=0: datain is the parity byte. Write it, set err <= (parity != datain) on the next edge, go DECODE.
  - When full: no write, state held, sender holds.
- DROP: busy=0. Consume bytes without writing. On packet_valid=0 (parity byte), pulse drop for one cycle and go DECODE.
- FIFO:
  - Count width clog2(DEPTH+1); full when count==DEPTH; empty when count==0.
  - Pointers wrap modulo DEPTH.
  - Simultaneous read+write leaves count unchanged.
  - Write when full is ignored; this cannot occur because busy blocks it.
- Read path:
  - read_enb[c] && !empty: data_out[c] <= head entry next cycle; pointer advances.
  - Read when empty: data_out holds its value, no pointer change.
- Timeout, per channel:
  - Counter increments while vld_out[c]=1 && read_enb[c]=0; clears otherwise.
  - On reaching TIMEOUT: flush FIFO c (pointers/count to 0), data_out[c] <= 0, counter to 0.
  - If the FSM is in WAIT or LOAD targeting c at that edge, it goes to DROP and the remainder of the packet is discarded; drop pulses at its end.
- err is a level signal; it updates only at parity-byte acceptance.
- No bytes are accepted in the DECODE cycle when packet_valid=0.

Optional Feature:
- ROUTER_STATS_EN defined:
  - pkt_cnt increments on each parity byte accepted in LOAD.
  - err_cnt increments when that packet's parity mismatches.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Not defined: pkt_cnt and err_cnt are tied to 0 and no counter registers are built.

Test Plan:
- NUM_CH=3, DEPTH=16. Header 8'h0D (addr 1), payload 8'h11,8'h22, parity 8'h3E, then read_enb[1]=1 -> data_out[15:8] reads 0D,11,22,3E; err=0; busy stays 0.
- Same packet with parity 8'h3F -> err=1 one cycle after the parity byte; next good packet returns err to 0.
- Header addr 3 (8'h07) with 2 payload bytes -> no FIFO writes; vld_out=0; drop pulses once after the parity byte.
- Channel 0 stream of 20 payload bytes, no reads -> busy=1 once count==16. Asserting read_enb[0] for 1 cycle -> 1 further byte accepted; total bytes in FIFO never exceed 16.
- Channel 2 holds data, read_enb[2]=0 for 30 cycles -> FIFO 2 flushed, vld_out[2]=0, data_out[23:16]=0. A packet in progress to channel 2 is dropped and drop pulses.
- resetn=0 mid-LOAD -> next cycle busy=0, all vld_out=0, err=0. With ROUTER_STATS_EN defined, 3 packets (1 bad parity) -> pkt_cnt=3, err_cnt=1.
